fifo_uart_tx: RTL and testbench

- Downstream consumer of the 8x8 async FIFO. Runs in the FIFO read-clock domain.
- Pops one byte at a time through the FIFO read port (read_en / mem_empty / out).
- Serializes each byte onto a UART-style line: start bit, 8 data bits LSB first, optional parity, 1 stop bit.
- Drives the external serial TX pin of the design.

---
 rtl/fifo_uart_tx_if.sv | 26 ++
 rtl/fifo_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx_if
// Brief    : FIFO read-port and serial-line bundle for fifo_uart_tx.
// Revision : 1.0  initial release
// ============================================================================
interface fifo_uart_tx_if;
  logic       tx_enable;
  logic       mem_empty;
  logic [7:0] data_in;
  logic       read_en;
  logic       tx_out;
  logic       busy;
  logic       byte_done;

  modport master (
    input  tx_enable, mem_empty, data_in,
    output read_en, tx_out, busy, byte_done
  );

  modport slave (
    output tx_enable, mem_empty, data_in,
    input  read_en, tx_out, busy, byte_done
  );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Pops bytes from the async FIFO read port and sends them as UART
//            frames (start, 8 data LSB first, optional even parity, stop).
//            Parity is enabled by defining FIFO_UART_TX_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           read_clk,
  input  logic           reset,
  fifo_uart_tx_if.master tx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_bit_last = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_e;

  state_e        state_q,   state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q,   shift_d;
  logic          read_en_q, read_en_d;
  logic          tx_out_q,  tx_out_d;
  logic          done_q,    done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          parity_q,  parity_d;
`endif

  logic w_bit_end;
  logic w_fetch;

  assign w_bit_end = (clk_cnt_q == c_bit_last);
  assign w_fetch   = tx_bus.tx_enable && !tx_bus.mem_empty;

  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      read_en_q <= 1'b0;
      tx_out_q  <= 1'b1;
      done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      read_en_q <= read_en_d;
      tx_out_q  <= tx_out_d;
      done_q    <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    read_en_d = 1'b0;
    done_d    = 1'b0;
    tx_out_d  = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_fetch) begin
          state_d   = S_REQ;
          read_en_d = 1'b1;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        // data_in was refreshed by the pop on the edge that ended REQ
        shift_d   = tx_bus.data_in;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = S_START;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = ^tx_bus.data_in;
`endif
      end
      S_START: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (w_bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (w_bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (w_bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (w_bit_end) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          if (w_fetch) begin
            state_d   = S_REQ;
            read_en_d = 1'b1;
          end else begin
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decided from the upcoming state so tx_out stays registered
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: tx_out_d = parity_d;
`endif
      default:  tx_out_d = 1'b1;
    endcase
  end

  assign tx_bus.read_en   = read_en_q;
  assign tx_bus.tx_out    = tx_out_q;
  assign tx_bus.byte_done = done_q;
  assign tx_bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Directed self-checking bench for fifo_uart_tx with a queue FIFO.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS   = 11;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int NBITS   = 10;
  localparam bit HAS_PAR = 1'b0;
`endif
  localparam int FRAME  = NBITS * CPB;
  localparam int TR_LEN = 256;

  logic       read_clk = 1'b0;
  logic       reset    = 1'b0;
  logic       tx_en    = 1'b0;
  logic       empty_r  = 1'b1;
  logic [7:0] data_r   = 8'h00;
  logic [7:0] fifo_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic tr_tx  [TR_LEN];
  logic tr_re  [TR_LEN];
  logic tr_bd  [TR_LEN];
  logic tr_busy[TR_LEN];
  int   r_idx;

  fifo_uart_tx_if bus ();

  assign bus.tx_enable = tx_en;
  assign bus.mem_empty = empty_r;
  assign bus.data_in   = data_r;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .read_clk (read_clk),
    .reset    (reset),
    .tx_bus   (bus)
  );

  always #5 read_clk = ~read_clk;

  // FIFO read side: pop on read_en, empty flag synchronous to read_clk
  always @(posedge read_clk) begin
    if (bus.read_en && fifo_q.size() > 0) data_r <= fifo_q.pop_front();
    empty_r <= (fifo_q.size() == 0);
  end

  function automatic logic exp_tx(input logic [7:0] b, input logic par, input int k);
    int bi;
    bi = k / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    if (HAS_PAR && bi == 9) return par;
    return 1'b1;
  endfunction

  task automatic capture(input int n, input int drop_off);
    r_idx = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge read_clk);
      tr_tx[i]   = bus.tx_out;
      tr_re[i]   = bus.read_en;
      tr_bd[i]   = bus.byte_done;
      tr_busy[i] = bus.busy;
      if (r_idx < 0 && bus.read_en) r_idx = i;
      if (drop_off >= 0 && r_idx >= 0 && i == r_idx + drop_off) tx_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    tx_en = 1'b0;
    fifo_q.delete();
    @(negedge read_clk);
    reset = 1'b0;
    repeat (3) @(negedge read_clk);
    reset = 1'b1;
    repeat (2) @(negedge read_clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge read_clk);
    n_tests++; if (bus.tx_out !== 1'b1)    begin n_fail++; $display("FAIL rst_tx_out: got %b want 1", bus.tx_out); end
    n_tests++; if (bus.read_en !== 1'b0)   begin n_fail++; $display("FAIL rst_read_en: got %b want 0", bus.read_en); end
    n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.byte_done !== 1'b0) begin n_fail++; $display("FAIL rst_byte_done: got %b want 0", bus.byte_done); end
    reset = 1'b1;
    @(negedge read_clk);
    fifo_q.push_back(8'h5A);
    tx_en = 1'b1;
    // 18 negedges later the frame is in data bit 2 of 0x5A (a low bit)
    repeat (18) @(negedge read_clk);
    n_tests++; if (bus.tx_out !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_abort_midframe: got tx=%b busy=%b want tx=0 busy=1", bus.tx_out, bus.busy);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (bus.tx_out !== 1'b1)    begin n_fail++; $display("FAIL abort_tx_out: got %b want 1", bus.tx_out); end
    n_tests++; if (bus.read_en !== 1'b0)   begin n_fail++; $display("FAIL abort_read_en: got %b want 0", bus.read_en); end
    n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.byte_done !== 1'b0) begin n_fail++; $display("FAIL abort_byte_done: got %b want 0", bus.byte_done); end
    tx_en = 1'b0;
    fifo_q.delete();
    @(negedge read_clk);
    reset = 1'b1;
    capture(20, -1);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) if (tr_busy[i] !== 1'b0 || tr_tx[i] !== 1'b1) bad++;
      n_tests++; if (r_idx != -1) begin n_fail++; $display("FAIL post_reset_read_en: got pulse at %0d want none", r_idx); end
      n_tests++; if (bad != 0)    begin n_fail++; $display("FAIL post_reset_idle: got %0d non-idle cycles want 0", bad); end
    end
  endtask

  task automatic test_empty();
    int low_cnt, busy_cnt;
    do_reset();
    tx_en = 1'b1;
    capture(100, -1);
    tx_en = 1'b0;
    low_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (tr_tx[i] !== 1'b1)   low_cnt++;
      if (tr_busy[i] !== 1'b0) busy_cnt++;
    end
    n_tests++; if (r_idx != -1)  begin n_fail++; $display("FAIL empty_read_en: got pulse at %0d want none", r_idx); end
    n_tests++; if (low_cnt != 0) begin n_fail++; $display("FAIL empty_tx_out: got %0d low cycles want 0", low_cnt); end
    n_tests++; if (busy_cnt != 0) begin n_fail++; $display("FAIL empty_busy: got %0d busy cycles want 0", busy_cnt); end
  endtask

  task automatic test_frame(input logic [7:0] b, input logic par);
    int re_cnt, bd_cnt, s;
    do_reset();
    @(negedge read_clk);
    fifo_q.push_back(b);
    tx_en = 1'b1;
    capture(FRAME + 20, -1);
    tx_en = 1'b0;
    n_tests++;
    if (r_idx < 0) begin
      n_fail++; $display("FAIL frame_%h_fetch: got no read_en want one pulse", b);
      return;
    end
    re_cnt = 0; bd_cnt = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      if (tr_re[i] === 1'b1) re_cnt++;
      if (tr_bd[i] === 1'b1) bd_cnt++;
    end
    s = r_idx + 2;
    n_tests++; if (re_cnt != 1) begin n_fail++; $display("FAIL frame_%h_read_en_count: got %0d want 1", b, re_cnt); end
    n_tests++; if (tr_tx[r_idx] !== 1'b1 || tr_tx[r_idx+1] !== 1'b1) begin
      n_fail++; $display("FAIL frame_%h_lead_idle: got %b%b want 11", b, tr_tx[r_idx], tr_tx[r_idx+1]);
    end
    for (int k = 0; k < FRAME; k++) begin
      n_tests++;
      if (tr_tx[s+k] !== exp_tx(b, par, k)) begin
        n_fail++; $display("FAIL frame_%h_tx cycle %0d: got %b want %b", b, k, tr_tx[s+k], exp_tx(b, par, k));
      end
    end
    n_tests++; if (tr_bd[s+FRAME] !== 1'b1) begin n_fail++; $display("FAIL frame_%h_byte_done_time: got %b want 1", b, tr_bd[s+FRAME]); end
    n_tests++; if (bd_cnt != 1) begin n_fail++; $display("FAIL frame_%h_byte_done_count: got %0d want 1", b, bd_cnt); end
    n_tests++; if (tr_busy[s+FRAME] !== 1'b0 || tr_tx[s+FRAME] !== 1'b1) begin
      n_fail++; $display("FAIL frame_%h_end_idle: got busy=%b tx=%b want busy=0 tx=1", b, tr_busy[s+FRAME], tr_tx[s+FRAME]);
    end
  endtask

  task automatic test_back_to_back();
    int re_cnt, bd_cnt, s0, s1;
    do_reset();
    @(negedge read_clk);
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    tx_en = 1'b1;
    capture(2 * FRAME + 30, -1);
    tx_en = 1'b0;
    n_tests++;
    if (r_idx < 0) begin
      n_fail++; $display("FAIL b2b_fetch: got no read_en want two pulses");
      return;
    end
    re_cnt = 0; bd_cnt = 0;
    for (int i = 0; i < 2 * FRAME + 30; i++) begin
      if (tr_re[i] === 1'b1) re_cnt++;
      if (tr_bd[i] === 1'b1) bd_cnt++;
    end
    s0 = r_idx + 2;
    s1 = s0 + FRAME + 2;
    n_tests++; if (re_cnt != 2) begin n_fail++; $display("FAIL b2b_read_en_count: got %0d want 2", re_cnt); end
    n_tests++; if (bd_cnt != 2) begin n_fail++; $display("FAIL b2b_byte_done_count: got %0d want 2", bd_cnt); end
    n_tests++; if (tr_re[s0+FRAME] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_req: got %b want 1", tr_re[s0+FRAME]); end
    n_tests++; if (tr_bd[s0+FRAME] !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", tr_bd[s0+FRAME]); end
    n_tests++; if ({tr_tx[s1-3], tr_tx[s1-2], tr_tx[s1-1], tr_tx[s1]} !== 4'b1110) begin
      n_fail++; $display("FAIL b2b_gap: got %b%b%b%b want 1110", tr_tx[s1-3], tr_tx[s1-2], tr_tx[s1-1], tr_tx[s1]);
    end
    for (int k = 0; k < FRAME; k++) begin
      n_tests++;
      if (tr_tx[s0+k] !== exp_tx(8'h00, 1'b0, k)) begin
        n_fail++; $display("FAIL b2b_frame00 cycle %0d: got %b want %b", k, tr_tx[s0+k], exp_tx(8'h00, 1'b0, k));
      end
      n_tests++;
      if (tr_tx[s1+k] !== exp_tx(8'hFF, 1'b0, k)) begin
        n_fail++; $display("FAIL b2b_frameFF cycle %0d: got %b want %b", k, tr_tx[s1+k], exp_tx(8'hFF, 1'b0, k));
      end
    end
    n_tests++; if (tr_bd[s1+FRAME] !== 1'b1 || tr_busy[s1+FRAME] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_final_idle: got done=%b busy=%b want done=1 busy=0", tr_bd[s1+FRAME], tr_busy[s1+FRAME]);
    end
  endtask

  task automatic test_enable_drop();
    int re_cnt, s, late_busy;
    do_reset();
    @(negedge read_clk);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h81);
    tx_en = 1'b1;
    // offset 15 from REQ lands in the second cycle of data bit 2
    capture(FRAME + 30, 15);
    tx_en = 1'b0;
    n_tests++;
    if (r_idx < 0) begin
      n_fail++; $display("FAIL drop_fetch: got no read_en want one pulse");
      return;
    end
    s = r_idx + 2;
    re_cnt = 0; late_busy = 0;
    for (int i = 0; i < FRAME + 30; i++) begin
      if (tr_re[i] === 1'b1) re_cnt++;
      if (i >= s + FRAME && tr_busy[i] !== 1'b0) late_busy++;
    end
    n_tests++; if (re_cnt != 1) begin n_fail++; $display("FAIL drop_read_en_count: got %0d want 1", re_cnt); end
    for (int k = 0; k < FRAME; k++) begin
      n_tests++;
      if (tr_tx[s+k] !== exp_tx(8'h3C, 1'b0, k)) begin
        n_fail++; $display("FAIL drop_frame cycle %0d: got %b want %b", k, tr_tx[s+k], exp_tx(8'h3C, 1'b0, k));
      end
    end
    n_tests++; if (tr_bd[s+FRAME] !== 1'b1) begin n_fail++; $display("FAIL drop_byte_done: got %b want 1", tr_bd[s+FRAME]); end
    n_tests++; if (late_busy != 0) begin n_fail++; $display("FAIL drop_busy_after: got %0d busy cycles want 0", late_busy); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_frame(8'hA5, 1'b0);
    test_frame(8'h07, 1'b1);
    test_back_to_back();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
